// File: rtl/alu_ctrl_pkg.sv
// Shared constants and state type for the ALU control / multiply-divide slice.
package alu_ctrl_pkg;

    localparam logic [3:0] OP_ADD     = 4'b0010;
    localparam logic [3:0] OP_SUB     = 4'b0110;
    localparam logic [3:0] OP_AND     = 4'b0000;
    localparam logic [3:0] OP_OR      = 4'b0001;
    localparam logic [3:0] OP_NOR     = 4'b1100;
    localparam logic [3:0] OP_SLT     = 4'b0111;
    localparam logic [3:0] OP_INVALID = 4'b1111;

    localparam logic [1:0] ALUOP_ADD     = 2'b00;
    localparam logic [1:0] ALUOP_SUB     = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE   = 2'b10;
    localparam logic [1:0] ALUOP_INVALID = 2'b11;

    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_NOR   = 6'b100111;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } md_state_t;

endpackage

// File: rtl/md_iter_engine.sv
// Iterative multiply (shift-add) / divide (restoring) engine owning HI and LO.
// The divider is present only when ALU_CTRL_DIV_EN is defined.
module md_iter_engine
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    md_state_t          state, state_nxt;
    logic [CW-1:0]      iter_cnt;
    logic [WIDTH:0]     acc_hi, acc_hi_nxt;
    logic [WIDTH-1:0]   acc_lo, acc_lo_nxt;
    logic [WIDTH-1:0]   opnd;
    logic               neg_lo, neg_hi;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_prod;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

`ifdef ALU_CTRL_DIV_EN
    logic               is_div_q, div_zero;
    logic [WIDTH-1:0]   raw_a;
    logic [WIDTH:0]     div_shift, div_trial;
`else
    logic               unused_is_div;
    assign unused_is_div = is_div;
`endif

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? -x : x;
    endfunction

    assign mag_a = magnitude(src_a, is_signed);
    assign mag_b = magnitude(src_b, is_signed);
    assign busy  = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef ALU_CTRL_DIV_EN
                    state_nxt = is_div ? DIV : MUL;
`else
                    state_nxt = MUL;
`endif
                end
            end
            MUL, DIV: begin
                if (iter_cnt == LAST_ITER)
                    state_nxt = FIX;
            end
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One iteration step; acc_hi carries the partial product upper half or the remainder.
    always_comb begin
        mul_sum    = {1'b0, acc_hi[WIDTH-1:0]} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        acc_hi_nxt = {1'b0, mul_sum[WIDTH:1]};
        acc_lo_nxt = {mul_sum[0], acc_lo[WIDTH-1:1]};
`ifdef ALU_CTRL_DIV_EN
        div_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
        div_trial = div_shift - {1'b0, opnd};
        if (state == DIV) begin
            if (!div_trial[WIDTH]) begin
                acc_hi_nxt = div_trial;
                acc_lo_nxt = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                acc_hi_nxt = div_shift;
                acc_lo_nxt = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    always_comb begin
        mul_prod = {acc_hi[WIDTH-1:0], acc_lo};
        if (neg_lo)
            mul_prod = -mul_prod;
        fix_hi = mul_prod[2*WIDTH-1:WIDTH];
        fix_lo = mul_prod[WIDTH-1:0];
`ifdef ALU_CTRL_DIV_EN
        // Divide by zero bypasses the sign fix so HI keeps the raw dividend.
        if (is_div_q) begin
            if (div_zero) begin
                fix_lo = '1;
                fix_hi = raw_a;
            end else begin
                fix_lo = neg_lo ? -acc_lo : acc_lo;
                fix_hi = neg_hi ? -acc_hi[WIDTH-1:0] : acc_hi[WIDTH-1:0];
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            iter_cnt <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            hi       <= '0;
            lo       <= '0;
`ifdef ALU_CTRL_DIV_EN
            is_div_q <= 1'b0;
            div_zero <= 1'b0;
            raw_a    <= '0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        iter_cnt <= '0;
                        acc_hi   <= '0;
                        acc_lo   <= mag_b;
                        opnd     <= mag_a;
                        neg_lo   <= is_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                        neg_hi   <= is_signed && src_a[WIDTH-1];
`ifdef ALU_CTRL_DIV_EN
                        is_div_q <= is_div;
                        div_zero <= (src_b == '0);
                        raw_a    <= src_a;
                        if (is_div) begin
                            acc_lo <= mag_a;
                            opnd   <= mag_b;
                        end
`endif
                    end
                end
                MUL, DIV: begin
                    acc_hi   <= acc_hi_nxt;
                    acc_lo   <= acc_lo_nxt;
                    iter_cnt <= iter_cnt + CW'(1);
                end
                FIX: begin
                    hi       <= fix_hi;
                    lo       <= fix_lo;
                    iter_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/alu_control_md.sv
// ALU control decode with multiply/divide interlock; ALU_CTRL_DIV_EN enables div/divu.
module alu_control_md
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [3:0]       operation,
    output logic             md_sel,
    output logic [WIDTH-1:0] md_rdata,
    output logic             busy,
    output logic             stall
);

    logic             is_rtype, is_mult, is_div, is_md, is_mfhi, is_mflo;
    logic             md_signed, md_start;
    logic [WIDTH-1:0] hi, lo;

    assign is_rtype = (alu_op == ALUOP_RTYPE);
    assign is_mult  = is_rtype && (funct == FUNCT_MULT || funct == FUNCT_MULTU);
`ifdef ALU_CTRL_DIV_EN
    assign is_div   = is_rtype && (funct == FUNCT_DIV || funct == FUNCT_DIVU);
`else
    assign is_div   = 1'b0;
`endif
    assign is_md     = is_mult || is_div;
    assign is_mfhi   = is_rtype && (funct == FUNCT_MFHI);
    assign is_mflo   = is_rtype && (funct == FUNCT_MFLO);
    assign md_signed = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);

    assign md_start = valid_in && is_md && !busy;
    assign stall    = valid_in && (is_md || is_mfhi || is_mflo) && busy;
    assign md_sel   = is_mfhi || is_mflo;
    assign md_rdata = is_mfhi ? hi : (is_mflo ? lo : '0);

    always_comb begin
        operation = OP_INVALID;
        case (alu_op)
            ALUOP_ADD:     operation = OP_ADD;
            ALUOP_SUB:     operation = OP_SUB;
            ALUOP_INVALID: operation = OP_INVALID;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD:   operation = OP_ADD;
                    FUNCT_SUB:   operation = OP_SUB;
                    FUNCT_AND:   operation = OP_AND;
                    FUNCT_OR:    operation = OP_OR;
                    FUNCT_NOR:   operation = OP_NOR;
                    FUNCT_SLT:   operation = OP_SLT;
                    FUNCT_MFHI, FUNCT_MFLO, FUNCT_MULT, FUNCT_MULTU:
                                 operation = OP_AND;
`ifdef ALU_CTRL_DIV_EN
                    FUNCT_DIV, FUNCT_DIVU:
                                 operation = OP_AND;
`endif
                    default:     operation = OP_INVALID;
                endcase
            end
            default: operation = OP_INVALID;
        endcase
    end

    md_iter_engine #(.WIDTH(WIDTH)) u_engine (
        .clk       (clk),
        .rst       (rst),
        .start     (md_start),
        .is_div    (is_div),
        .is_signed (md_signed),
        .src_a     (src_a),
        .src_b     (src_b),
        .busy      (busy),
        .hi        (hi),
        .lo        (lo)
    );

endmodule

// File: tb/tb_alu_control_md.sv
// Self-checking bench for alu_control_md against an arithmetic reference model.
// Div/divu checks follow ALU_CTRL_DIV_EN the same way the design does.
module tb_alu_control_md;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid_in;
    logic [1:0]   alu_op;
    logic [5:0]   funct;
    logic [W-1:0] src_a, src_b;
    logic [3:0]   operation;
    logic         md_sel;
    logic [W-1:0] md_rdata;
    logic         busy;
    logic         stall;

    int checks = 0;
    int errors = 0;

    alu_control_md #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .alu_op    (alu_op),
        .funct     (funct),
        .src_a     (src_a),
        .src_b     (src_b),
        .operation (operation),
        .md_sel    (md_sel),
        .md_rdata  (md_rdata),
        .busy      (busy),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

`ifdef ALU_CTRL_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    // Expected ALU operation straight from the decode table.
    function automatic logic [3:0] dec_model(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'b00) return 4'b0010;
        if (op == 2'b01) return 4'b0110;
        if (op == 2'b11) return 4'b1111;
        case (f)
            6'b100000: return 4'b0010;
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b100111: return 4'b1100;
            6'b101010: return 4'b0111;
            6'b010000, 6'b010010, 6'b011000, 6'b011001: return 4'b0000;
            6'b011010, 6'b011011: return DIV_ON ? 4'b0000 : 4'b1111;
            default: return 4'b1111;
        endcase
    endfunction

    // Expected {HI, LO} using native 64-bit and signed arithmetic.
    function automatic logic [63:0] md_model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, prod;
        logic [63:0] up;
        logic signed [31:0] qs, rs;
        case (f)
            6'b011000: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                prod = sa * sb;
                return prod;
            end
            6'b011001: begin
                up = {32'h0, a} * {32'h0, b};
                return up;
            end
            6'b011010: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                qs = $signed(a) / $signed(b);
                rs = $signed(a) % $signed(b);
                return {rs, qs};
            end
            default: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b);
        valid_in = v;
        alu_op   = op;
        funct    = f;
        src_a    = a;
        src_b    = b;
    endtask

    task automatic bubble();
        drive(1'b0, 2'b00, 6'b000000, 32'h0, 32'h0);
    endtask

    // Presents an MD op for one edge, then counts cycles with busy high (bounded).
    task automatic issue_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                            output int cycles);
        int n;
        drive(1'b1, 2'b10, f, a, b);
        @(posedge clk); #1;
        bubble();
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(posedge clk); #1;
        end
        cycles = n;
    endtask

    task automatic read_hilo(output logic [31:0] hi_v, output logic [31:0] lo_v);
        drive(1'b1, 2'b10, 6'b010000, 32'h0, 32'h0);
        #1 hi_v = md_rdata;
        drive(1'b1, 2'b10, 6'b010010, 32'h0, 32'h0);
        #1 lo_v = md_rdata;
        bubble();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bubble();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: busy=%b stall=%b expected 0/0", busy, stall);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        drive(1'b1, 2'b10, 6'b010000, 32'h0, 32'h0);
        #1;
        checks++;
        if (md_rdata !== 32'h0 || md_sel !== 1'b1 || stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mfhi: rdata=%h sel=%b stall=%b expected 0/1/0", md_rdata, md_sel, stall);
        end
        drive(1'b1, 2'b10, 6'b010010, 32'h0, 32'h0);
        #1;
        checks++;
        if (md_rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_mflo: rdata=%h expected 0", md_rdata);
        end
        bubble();
    endtask

    task automatic test_decode();
        logic [1:0] ops [5] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b00};
        logic [5:0] fs  [5] = '{6'b100010, 6'b100111, 6'b111111, 6'b000000, 6'b101010};
        logic [1:0] op;
        logic [5:0] f;
        logic [3:0] exp;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, ops[i], fs[i], 32'h0, 32'h0);
            #1;
            exp = dec_model(ops[i], fs[i]);
            checks++;
            if (operation !== exp) begin
                errors++;
                $display("[TB] FAIL decode_dir%0d: op=%b funct=%b got %b expected %b", i, ops[i], fs[i], operation, exp);
            end
        end
        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom_range(3));
            f  = (i % 2 == 0) ? 6'($urandom) : 6'(6'b010000 + 6'($urandom_range(27)));
            drive(1'b0, op, f, 32'h0, 32'h0);
            #1;
            exp = dec_model(op, f);
            checks++;
            if (operation !== exp) begin
                errors++;
                $display("[TB] FAIL decode_rand: op=%b funct=%b got %b expected %b", op, f, operation, exp);
            end
        end
        bubble();
        @(posedge clk); #1;
    endtask

    task automatic test_mult_stall();
        int n;
        int bad_stall;
        logic [63:0] exp;
        exp = md_model(6'b011000, 32'hFFFF_FFFD, 32'd7);
        drive(1'b1, 2'b10, 6'b011000, 32'hFFFF_FFFD, 32'd7);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mult_issue_stall: stall=%b expected 0", stall);
        end
        @(posedge clk); #1;
        drive(1'b1, 2'b10, 6'b010010, 32'h0, 32'h0);
        #1;
        n = 0;
        bad_stall = 0;
        while (busy === 1'b1 && n < 200) begin
            if (stall !== 1'b1) bad_stall++;
            n++;
            @(posedge clk); #1;
        end
        checks++;
        if (n != W + 1 || bad_stall != 0) begin
            errors++;
            $display("[TB] FAIL mult_busy: busy cycles %0d expected %0d, unstalled cycles %0d", n, W + 1, bad_stall);
        end
        checks++;
        if (stall !== 1'b0 || md_rdata !== exp[31:0]) begin
            errors++;
            $display("[TB] FAIL mult_mflo: stall=%b rdata=%h expected 0/%h", stall, md_rdata, exp[31:0]);
        end
        drive(1'b1, 2'b10, 6'b010000, 32'h0, 32'h0);
        #1;
        checks++;
        if (md_rdata !== exp[63:32] || md_sel !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mult_mfhi: rdata=%h sel=%b expected %h/1", md_rdata, md_sel, exp[63:32]);
        end
        bubble();
    endtask

    task automatic test_random_md();
        logic [5:0] f;
        logic [31:0] a, b, hi_v, lo_v;
        logic [63:0] exp;
        int cyc;
        for (int i = 0; i < 14; i++) begin
            f = DIV_ON ? 6'(6'b011000 + 6'($urandom_range(3))) : 6'(6'b011000 + 6'($urandom_range(1)));
            a = $urandom;
            b = $urandom;
            case (i % 7)
                1: b = 32'h0;
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: b = 32'($urandom_range(15));
                4: a = 32'h0;
                default: ;
            endcase
            exp = md_model(f, a, b);
            issue_md(f, a, b, cyc);
            read_hilo(hi_v, lo_v);
            checks++;
            if (cyc != W + 1 || {hi_v, lo_v} !== exp) begin
                errors++;
                $display("[TB] FAIL md_rand: funct=%b a=%h b=%h got hi=%h lo=%h cyc=%0d expected hi=%h lo=%h cyc=%0d",
                         f, a, b, hi_v, lo_v, cyc, exp[63:32], exp[31:0], W + 1);
            end
        end
    endtask

`ifdef ALU_CTRL_DIV_EN
    task automatic test_div_directed();
        logic [31:0] hi_v, lo_v;
        int cyc;
        issue_md(6'b011010, 32'hFFFF_FFF9, 32'd2, cyc);
        read_hilo(hi_v, lo_v);
        checks++;
        if (hi_v !== 32'hFFFF_FFFF || lo_v !== 32'hFFFF_FFFD || cyc != W + 1) begin
            errors++;
            $display("[TB] FAIL div_neg7_2: hi=%h lo=%h cyc=%0d expected FFFFFFFF/FFFFFFFD/%0d", hi_v, lo_v, cyc, W + 1);
        end
        issue_md(6'b011011, 32'd7, 32'd0, cyc);
        read_hilo(hi_v, lo_v);
        checks++;
        if (hi_v !== 32'h7 || lo_v !== 32'hFFFF_FFFF) begin
            errors++;
            $display("[TB] FAIL divu_by_zero: hi=%h lo=%h expected 00000007/FFFFFFFF", hi_v, lo_v);
        end
    endtask
`else
    task automatic test_div_disabled();
        int cyc;
        drive(1'b1, 2'b10, 6'b011010, 32'd9, 32'd3);
        #1;
        checks++;
        if (operation !== 4'b1111 || stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL nodiv_decode: operation=%b stall=%b expected 1111/0", operation, stall);
        end
        @(posedge clk); #1;
        drive(1'b1, 2'b10, 6'b011011, 32'd9, 32'd3);
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || operation !== 4'b1111) begin
            errors++;
            $display("[TB] FAIL nodiv_busy: busy=%b operation=%b expected 0/1111", busy, operation);
        end
        drive(1'b1, 2'b10, 6'b011000, 32'd5, 32'd6);
        @(posedge clk); #1;
        drive(1'b1, 2'b10, 6'b011010, 32'd9, 32'd3);
        #1;
        checks++;
        if (busy !== 1'b1 || stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL nodiv_while_busy: busy=%b stall=%b expected 1/0", busy, stall);
        end
        bubble();
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            cyc++;
            @(posedge clk); #1;
        end
    endtask
`endif

    task automatic test_back_to_back();
        logic [5:0] f2;
        logic [31:0] a2, b2, hi_v, lo_v;
        logic [63:0] exp;
        int n, n2, bad_stall;
        f2 = DIV_ON ? 6'b011011 : 6'b011000;
        a2 = $urandom;
        b2 = 32'($urandom_range(1000, 1));
        exp = md_model(f2, a2, b2);
        drive(1'b1, 2'b10, 6'b011001, $urandom, $urandom);
        @(posedge clk); #1;
        drive(1'b1, 2'b10, f2, a2, b2);
        #1;
        n = 0;
        bad_stall = 0;
        while (busy === 1'b1 && n < 200) begin
            if (stall !== 1'b1) bad_stall++;
            n++;
            @(posedge clk); #1;
        end
        checks++;
        if (n != W + 1 || bad_stall != 0 || stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_stall: cycles %0d expected %0d, unstalled %0d, stall_after=%b", n, W + 1, bad_stall, stall);
        end
        @(posedge clk); #1;
        bubble();
        n2 = 0;
        while (busy === 1'b1 && n2 < 200) begin
            n2++;
            @(posedge clk); #1;
        end
        read_hilo(hi_v, lo_v);
        checks++;
        if (n2 != W + 1 || {hi_v, lo_v} !== exp) begin
            errors++;
            $display("[TB] FAIL b2b_result: hi=%h lo=%h cyc=%0d expected hi=%h lo=%h cyc=%0d",
                     hi_v, lo_v, n2, exp[63:32], exp[31:0], W + 1);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] hi_v, lo_v;
        drive(1'b1, 2'b10, 6'b011000, 32'd12345, 32'd678);
        @(posedge clk); #1;
        drive(1'b1, 2'b10, 6'b100000, 32'd1, 32'd2);
        #1;
        checks++;
        if (stall !== 1'b0 || busy !== 1'b1 || operation !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL add_while_busy: stall=%b busy=%b op=%b expected 0/1/0010", stall, busy, operation);
        end
        bubble();
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_busy: busy=%b stall=%b expected 0/0", busy, stall);
        end
        read_hilo(hi_v, lo_v);
        checks++;
        if (hi_v !== 32'h0 || lo_v !== 32'h0) begin
            errors++;
            $display("[TB] FAIL abort_hilo: hi=%h lo=%h expected 0/0", hi_v, lo_v);
        end
        repeat (W + 3) @(posedge clk);
        #1;
        read_hilo(hi_v, lo_v);
        checks++;
        if (busy !== 1'b0 || hi_v !== 32'h0 || lo_v !== 32'h0) begin
            errors++;
            $display("[TB] FAIL abort_no_write: busy=%b hi=%h lo=%h expected 0/0/0", busy, hi_v, lo_v);
        end
    endtask

    initial begin
        rst = 1'b1;
        bubble();
        test_reset();
        test_decode();
        test_mult_stall();
`ifdef ALU_CTRL_DIV_EN
        test_div_directed();
`else
        test_div_disabled();
`endif
        test_random_md();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_control_md.md
# alu_control_md

Parametrised ALU control with an iterative multiply/divide engine, the successor to the single-cycle ALU control in the datapath. It decodes `alu_op` and `funct` into a 4-bit ALU operation for single-cycle ops. It also accepts MIPS mult/multu/div/divu, runs them over several cycles into internal HI/LO registers, and interlocks mfhi/mflo and back-to-back mult/div with a stall output.

## Interface
- `WIDTH`, default 32: operand, HI and LO width; must be at least 4.
- `clk` input 1: rising-edge clock.
- `rst` input 1: synchronous, active-high reset.
- `valid_in` input 1: the instruction in decode is real (not a bubble).
- `alu_op` input 2: ALUOp from main control.
- `funct` input 6: instruction funct field.
- `src_a` input WIDTH: rs operand (multiplicand / dividend).
- `src_b` input WIDTH: rt operand (multiplier / divisor).
- `operation` output 4: ALU operation code.
- `md_sel` output 1: the writeback value comes from `md_rdata`, not the ALU.
- `md_rdata` output WIDTH: HI for mfhi, LO for mflo, else 0.
- `busy` output 1: engine is iterating.
- `stall` output 1: hold the pipeline front; the current instruction is not accepted.

## Operation
- Combinational decode of `operation`:
  - `alu_op` 00 → 0010 (add).
  - `alu_op` 01 → 0110 (sub).
  - `alu_op` 11 → 1111.
  - `alu_op` 10, by funct:
    - 100000 → 0010 (add)
    - 100010 → 0110 (sub)
    - 100100 → 0000 (and)
    - 100101 → 0001 (or)
    - 100111 → 1100 (nor)
    - 101010 → 0111 (slt)
    - 010000, 010010, 011000–011011 → 0000 (ALU result unused)
    - any other funct → 1111
- Multiply/divide ops (only when `alu_op`=10):
  - Functs 011000 mult, 011001 multu, 011010 div, 011011 divu.
  - Start condition: `valid_in` && MD op && !`busy`. On start, latch operand magnitudes, signedness and result signs, then enter the MUL or DIV state.
- Engine states:
  - IDLE → MUL or DIV on start.
  - MUL or DIV: one iteration per cycle for WIDTH cycles. MUL is shift-add; DIV is restoring division.
  - FIX: one cycle to apply signs and write HI/LO, then → IDLE.
- Results:
  - mult/multu: {HI,LO} = 2·WIDTH-bit product.
  - div/divu: LO = quotient, HI = remainder.
  - Signed quotient sign = sign(a) XOR sign(b). Signed remainder takes the dividend's sign.
  - Signed MIN / −1 gives LO = MIN, HI = 0.
  - Divide by zero (any signedness): LO = all ones, HI = `src_a` unchanged.
- mfhi (010000) and mflo (010010): `md_sel`=1 and `md_rdata` = HI or LO, combinationally from the registers.
- `stall` = `valid_in` && `alu_op`==10 && (MD op, mfhi or mflo) && `busy`.
  - A stalled MD op is not started. The pipeline re-presents it, and it starts on the cycle `busy` falls.
  - MD ops themselves never stall when the engine is idle (fire-and-forget).
- All other instructions pass while `busy`=1, with no effect on the engine.

## Timing
- Reset values: `busy`=0, `stall`=0, HI=LO=0, state IDLE, iteration counter 0. `operation`, `md_sel` and `md_rdata` are combinational from the inputs and the reset registers.
- Start accepted on edge T0.
- `busy`=1 from after T0 through edge T0+WIDTH+1, i.e. WIDTH+1 cycles.
- HI/LO update on edge T0+WIDTH+1, when `busy` falls. An mfhi/mflo held in the cycle after that edge reads the new value with `stall`=0.
- `rst` during MUL, DIV or FIX: abort with no HI/LO write, return to reset values next edge.
- Iteration counter is $clog2(WIDTH+1) bits and never wraps past WIDTH.

## Configuration
- `ALU_CTRL_DIV_EN` defined: DIV state, divider datapath and div/divu decode are present.
- Not defined:
  - funct 011010 and 011011 decode as 1111 and never start the engine, and never stall.
  - mult/multu, mfhi and mflo are unchanged.

## Structure
- Shared package `alu_ctrl_pkg`:
  - ALU op code constants (ADD, SUB, AND, OR, NOR, SLT, INVALID).
  - Funct constants.
  - ALUOp constants.
  - MD state enum (IDLE, MUL, DIV, FIX).
- Sub-module `md_iter_engine`: state machine, counter, shift-add and restoring-divide datapath, HI/LO registers. The top holds decode and the stall logic.

## Test plan
- Decode sweep: `alu_op`=10 with funct 100010 → 0110; 100111 → 1100; 111111 → 1111; `alu_op`=01 → 0110.
- mult with a=−3, b=7 → after WIDTH+1 busy cycles, HI=FFFFFFFF, LO=FFFFFFEB; mflo issued during busy stalls, then reads FFFFFFEB.
- div with a=−7, b=2 → LO=FFFFFFFD, HI=FFFFFFFF; divu with a=7, b=0 → LO=FFFFFFFF, HI=00000007.
- Back-to-back: multu, then divu presented while busy → `stall`=1 until `busy` falls, then divu starts; final HI/LO match divu.
- `rst` asserted mid-MUL at iteration 10 → next cycle `busy`=0, HI=LO=0, mfhi returns 0.
- Build without `ALU_CTRL_DIV_EN`: div funct → `operation`=1111, `busy` stays 0, `stall`=0.
